// File: rtl/exec_step_controller.sv
// exec_step_controller: run/step/breakpoint/halt controller for the six-instruction
// processor. Generates the processor clock enable and keeps saturating
// cycle/instruction counters for the HEX display mux.
//
// Ports:
//   Clk, Reset    single clock, synchronous active-high reset
//   Run           level, run continuously while high
//   Step          level from button, rising edge requests one instruction
//   BpEn, BpAddr  PC breakpoint enable and address
//   PC_In, IR_In, StateIn   processor PC, IR and FSM state fed back
//   ProcEn        combinational clock enable to the processor
//   Halted        sticky, halt opcode reached
//   AtBreak       stopped on a breakpoint
//   DbgState      IDLE=0, RUN=1, STEP=2, HALT=3
//   CycleCount    enabled processor cycles, saturating
//   InstrCount    committed fetches, saturating
module exec_step_controller #(
    parameter int unsigned PC_W     = 7,
    parameter int unsigned IR_W     = 16,
    parameter logic [3:0]  FETCH_ST = 4'd1,
    parameter logic [3:0]  HALT_OP  = 4'h5
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Run,
    input  logic            Step,
    input  logic            BpEn,
    input  logic [PC_W-1:0] BpAddr,
    input  logic [PC_W-1:0] PC_In,
    input  logic [IR_W-1:0] IR_In,
    input  logic [3:0]      StateIn,
    output logic            ProcEn,
    output logic            Halted,
    output logic            AtBreak,
    output logic [1:0]      DbgState,
    output logic [15:0]     CycleCount,
    output logic [15:0]     InstrCount
);

    localparam int unsigned CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_HALT = 2'd3
    } dbg_state_e;

    dbg_state_e       state_q, state_d;
    logic             step_q;
    logic             armed_q, armed_d;
    logic             left_q, left_d;
    logic             at_break_q, at_break_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instr_q, instr_d;
    logic             proc_en_c;

    logic at_fetch;
    logic halt_hit;
    logic bp_hit;
    logic step_edge;

    // Opcode lives in the top nibble of IR; the rest of IR is not needed here.
    logic [IR_W-5:0] unused_ir;
    assign unused_ir = IR_In[IR_W-5:0];

    assign at_fetch  = (StateIn == FETCH_ST);
    assign halt_hit  = (IR_In[IR_W-1 -: 4] == HALT_OP) && !at_fetch;
    assign bp_hit    = at_fetch && BpEn && (PC_In == BpAddr) && armed_q;
    assign step_edge = Step && !step_q;

    // Next-state and enable; stop conditions gate the enable in the same cycle.
    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q;
        left_d     = left_q;
        at_break_d = at_break_q;
        halted_d   = halted_q;
        proc_en_c  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (Run) begin
                    state_d    = ST_RUN;
                    armed_d    = 1'b0;
                    left_d     = 1'b0;
                    at_break_d = 1'b0;
                end else if (step_edge) begin
                    state_d    = ST_STEP;
                    armed_d    = 1'b0;
                    left_d     = 1'b0;
                    at_break_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (halt_hit) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else if (bp_hit) begin
                    state_d    = ST_IDLE;
                    at_break_d = 1'b1;
                end else if (at_fetch && !Run && left_q) begin
                    state_d = ST_IDLE;
                end else begin
                    proc_en_c = 1'b1;
                end
            end
            ST_STEP: begin
                // Breakpoints deliberately not consulted while stepping.
                if (halt_hit) begin
                    state_d  = ST_HALT;
                    halted_d = 1'b1;
                end else if (at_fetch && left_q) begin
                    state_d = ST_IDLE;
                end else begin
                    proc_en_c = 1'b1;
                end
            end
            ST_HALT: begin
                proc_en_c = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // One enabled cycle means the processor has left the boundary it started on.
        if (proc_en_c) begin
            armed_d = 1'b1;
            left_d  = 1'b1;
        end
    end

    assign ProcEn = proc_en_c && !Reset;

    // Saturating counters.
    always_comb begin
        cycle_d = cycle_q;
        instr_d = instr_q;
        if (ProcEn && (cycle_q != CNT_MAX)) begin
            cycle_d = cycle_q + CNT_W'(1);
        end
        if (ProcEn && at_fetch && (instr_q != CNT_MAX)) begin
            instr_d = instr_q + CNT_W'(1);
        end
    end

    // State and counter registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            step_q     <= 1'b0;
            armed_q    <= 1'b0;
            left_q     <= 1'b0;
            at_break_q <= 1'b0;
            halted_q   <= 1'b0;
            cycle_q    <= '0;
            instr_q    <= '0;
        end else begin
            state_q    <= state_d;
            step_q     <= Step;
            armed_q    <= armed_d;
            left_q     <= left_d;
            at_break_q <= at_break_d;
            halted_q   <= halted_d;
            cycle_q    <= cycle_d;
            instr_q    <= instr_d;
        end
    end

    assign DbgState   = 2'(state_q);
    assign Halted     = halted_q;
    assign AtBreak    = at_break_q;
    assign CycleCount = cycle_q;
    assign InstrCount = instr_q;

endmodule

// File: tb/tb_exec_step_controller.sv
// Bench for exec_step_controller: directed scenarios plus a randomized phase,
// all checked cycle by cycle against a behavioural model of the controller
// driving a simple 3-cycle processor model (StateIn 1,2,3; PC advances at fetch).
module tb_exec_step_controller;

    logic        clk;
    logic        reset;
    logic        run;
    logic        step;
    logic        bp_en;
    logic [6:0]  bp_addr;
    logic [6:0]  pc;
    logic [15:0] ir;
    logic [3:0]  st;
    logic        proc_en;
    logic        halted;
    logic        at_break;
    logic [1:0]  dbg;
    logic [15:0] cc;
    logic [15:0] ic;

    // Reference model state
    int m_mode;       // 0 idle, 1 run, 2 step, 3 halt
    int m_en_cnt;     // enabled cycles since entering run/step
    int m_cc;
    int m_ic;
    bit m_halted;
    bit m_atbrk;
    bit m_prev_step;

    int       n_checks;
    int       n_pass;
    int       n_en;
    logic [6:0] pc_mask;
    bit       rand_ir;
    bit       found;

    exec_step_controller dut (
        .Clk        (clk),
        .Reset      (reset),
        .Run        (run),
        .Step       (step),
        .BpEn       (bp_en),
        .BpAddr     (bp_addr),
        .PC_In      (pc),
        .IR_In      (ir),
        .StateIn    (st),
        .ProcEn     (proc_en),
        .Halted     (halted),
        .AtBreak    (at_break),
        .DbgState   (dbg),
        .CycleCount (cc),
        .InstrCount (ic)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // One clock cycle: called at negedge with inputs already driven.
    task automatic tick();
        bit b, hh, edge_s, en, brk;
        int nm;
        #1;
        b      = (st == 4'd1);
        hh     = (ir[15:12] == 4'h5) && !b;
        edge_s = step && !m_prev_step;
        en     = 1'b0;
        brk    = 1'b0;
        nm     = m_mode;

        chk("dbg_state", 32'(dbg), 32'(m_mode));
        chk("halted", 32'(halted), 32'(m_halted));
        chk("at_break", 32'(at_break), 32'(m_atbrk));
        chk("cycle_count", 32'(cc), 32'(m_cc));
        chk("instr_count", 32'(ic), 32'(m_ic));

        if (!reset) begin
            if (m_mode == 0) begin
                if (run) nm = 1;
                else if (edge_s) nm = 2;
            end else if (m_mode == 1) begin
                if (hh) nm = 3;
                else if (b && bp_en && pc == bp_addr && m_en_cnt > 0) begin
                    nm  = 0;
                    brk = 1'b1;
                end else if (b && !run && m_en_cnt > 0) nm = 0;
                else en = 1'b1;
            end else if (m_mode == 2) begin
                if (hh) nm = 3;
                else if (b && m_en_cnt > 0) nm = 0;
                else en = 1'b1;
            end
        end
        chk("proc_en", 32'(proc_en), 32'(en));
        if (en) n_en++;

        @(posedge clk);
        #1;
        if (reset) begin
            m_mode = 0; m_en_cnt = 0; m_cc = 0; m_ic = 0;
            m_halted = 0; m_atbrk = 0; m_prev_step = 0;
            st = 4'd1; pc = 7'd0;
        end else begin
            if (m_mode == 0 && nm != 0) begin
                m_en_cnt = 0;
                m_atbrk  = 0;
            end
            if (brk) m_atbrk = 1;
            if (nm == 3) m_halted = 1;
            if (en) begin
                m_en_cnt++;
                m_cc = (m_cc < 65535) ? m_cc + 1 : 65535;
                if (b) begin
                    m_ic = (m_ic < 65535) ? m_ic + 1 : 65535;
                    pc = (pc + 7'd1) & pc_mask;
                    if (rand_ir)
                        ir = ($urandom_range(0, 29) == 0) ? 16'h5000
                             : {4'($urandom_range(0, 4)), 12'($urandom)};
                end
                st = (st == 4'd3) ? 4'd1 : st + 4'd1;
            end
            m_prev_step = step;
            m_mode = nm;
        end
        @(negedge clk);
    endtask

    initial begin
        clk = 0; reset = 1; run = 0; step = 0; bp_en = 0; bp_addr = 7'd0;
        st = 4'd1; pc = 7'd0; ir = 16'h1000; pc_mask = 7'h7F; rand_ir = 0;
        m_mode = 0; m_en_cnt = 0; m_cc = 0; m_ic = 0;
        m_halted = 0; m_atbrk = 0; m_prev_step = 0;
        n_checks = 0; n_pass = 0; n_en = 0; found = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // 1. Reset then idle
        tick();
        reset = 0;
        repeat (10) tick();
        chk("t1_proc_en", 32'(proc_en), 32'd0);
        chk("t1_dbg", 32'(dbg), 32'd0);
        chk("t1_cc", 32'(cc), 32'd0);
        chk("t1_ic", 32'(ic), 32'd0);

        // 2. Single step, Step held high afterwards
        n_en = 0;
        step = 1;
        repeat (9) tick();
        chk("t2_en_cycles", 32'(n_en), 32'd3);
        chk("t2_state_fetch", 32'(st), 32'd1);
        chk("t2_idle", 32'(dbg), 32'd0);
        chk("t2_ic", 32'(ic), 32'd1);
        chk("t2_cc", 32'(cc), 32'd3);
        step = 0;
        tick();

        // 3. Breakpoint at PC 4, then resume past it
        reset = 1; tick(); reset = 0;
        bp_en = 1; bp_addr = 7'h04; run = 1; found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (dbg == 2'd0 && at_break) found = 1;
        end
        run = 0;
        chk("t3_bp_reached", 32'(found), 32'd1);
        chk("t3_pc", 32'(pc), 32'd4);
        chk("t3_st", 32'(st), 32'd1);
        chk("t3_at_break", 32'(at_break), 32'd1);
        chk("t3_dbg", 32'(dbg), 32'd0);
        tick();
        run = 1;
        repeat (12) tick();
        chk("t3_resumed", 32'(pc > 7'd4), 32'd1);
        chk("t3_break_clr", 32'(at_break), 32'd0);
        chk("t3_running", 32'(dbg), 32'd1);
        bp_en = 0;

        // 4. Halt opcode mid-instruction
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (st == 4'd2) found = 1;
            else tick();
        end
        chk("t4_mid_instr", 32'(found), 32'd1);
        ir = 16'h5000;
        #1 chk("t4_proc_en_halt", 32'(proc_en), 32'd0);
        tick();
        chk("t4_halted", 32'(halted), 32'd1);
        chk("t4_dbg", 32'(dbg), 32'd3);
        for (int i = 0; i < 6; i++) begin
            run  = 1'(i);
            step = ~step;
            tick();
            chk("t4_stuck", 32'(dbg), 32'd3);
        end
        run = 0; step = 0; reset = 1; ir = 16'h1000;
        tick();
        reset = 0;
        tick();

        // 5. Run release mid-instruction, then Run + Step edge together
        run = 1;
        repeat (5) tick();
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (st != 4'd1) found = 1;
            else tick();
        end
        run = 0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (dbg == 2'd0) found = 1;
        end
        chk("t5_stopped", 32'(found), 32'd1);
        chk("t5_at_fetch", 32'(st), 32'd1);
        run = 1; step = 1;
        tick();
        chk("t5_run_wins", 32'(dbg), 32'd1);
        run = 0;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (dbg == 2'd0) found = 1;
        end
        repeat (3) tick();
        chk("t5_step_dropped", 32'(dbg), 32'd0);
        step = 0;
        tick();

        // Randomized phase
        pc_mask = 7'h0F; rand_ir = 1;
        reset = 1; tick(); reset = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0) run = ~run;
            if ($urandom_range(0, 3) == 0) step = ~step;
            if ($urandom_range(0, 49) == 0) begin
                bp_en   = 1'($urandom_range(0, 1));
                bp_addr = 7'($urandom_range(0, 15));
            end
            reset = ($urandom_range(0, 149) == 0);
            tick();
        end
        reset = 0; rand_ir = 0; ir = 16'h1000; pc_mask = 7'h7F;
        run = 0; step = 0; bp_en = 0;

        // 6. Saturation, then reset while running
        reset = 1; tick(); reset = 0;
        run = 1;
        repeat (65540) tick();
        chk("t6_cc_sat", 32'(cc), 32'h0000FFFF);
        reset = 1;
        #1 chk("t6_proc_en_reset", 32'(proc_en), 32'd0);
        tick();
        reset = 0;
        chk("t6_dbg", 32'(dbg), 32'd0);
        chk("t6_cc", 32'(cc), 32'd0);
        chk("t6_ic", 32'(ic), 32'd0);
        run = 0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
